// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display:
// one shared nibble decoder, dead-time blanking, leading-zero suppression, frame-aligned loads.
module seg_scan_ctrl #(
   parameter int unsigned NUM_DIGITS   = 4,
   parameter int unsigned TICK_DIV     = 50000,
   parameter int unsigned BLANK_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic                    lz_en,
   input  logic                    load_valid,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   output logic                    load_ready,
   output logic [3:0]              nibble,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    seg_blank,
   output logic                    frame_done
);

   localparam int unsigned DATA_W     = 4 * NUM_DIGITS;
   localparam int unsigned IDX_W      = $clog2(NUM_DIGITS);
   localparam int unsigned CNT_MAX    = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
   localparam int unsigned CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int unsigned TICK_LAST  = TICK_DIV - 1;
   localparam int unsigned BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
   localparam int unsigned LAST_IDX   = NUM_DIGITS - 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_BLANK = 2'd2
   } state_t;

   state_t                r_state;
   logic [IDX_W-1:0]      r_idx;
   logic [CNT_W-1:0]      r_cnt;
   logic [DATA_W-1:0]     r_active;
   logic [DATA_W-1:0]     r_staging;
   logic                  r_load_ready;
   logic [3:0]            r_nibble;
   logic [NUM_DIGITS-1:0] r_digit_sel;
   logic                  r_seg_blank;
   logic                  r_frame_done;

   logic                  w_last_idx;
   logic                  w_drive_end;
   logic                  w_blank_end;
   logic                  w_frame_end;
   logic                  w_xfer;
   logic [IDX_W-1:0]      w_next_idx;
   logic [DATA_W-1:0]     w_active_nxt;
   logic [NUM_DIGITS-1:0] w_next_sel;
   logic [NUM_DIGITS-1:0] w_start_sel;
   logic [3:0]            w_next_nib;
   logic [3:0]            w_start_nib;

   // Active-low select for a digit, left dark when it is a suppressed leading zero.
   function automatic logic [NUM_DIGITS-1:0] f_drive_sel(
      input logic [IDX_W-1:0]  idx,
      input logic [DATA_W-1:0] act,
      input logic              lz
   );
      logic upper_zero;
      upper_zero = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (k >= int'(idx) && 4'(act >> (4 * k)) != 4'd0) upper_zero = 1'b0;
      end
      if (lz && idx != '0 && upper_zero) return '1;
      return ~(NUM_DIGITS'(1) << idx);
   endfunction

   function automatic logic [3:0] f_nibble(
      input logic [IDX_W-1:0]  idx,
      input logic [DATA_W-1:0] act
   );
      return 4'(act >> (4 * idx));
   endfunction

   assign w_last_idx   = (r_idx == IDX_W'(LAST_IDX));
   assign w_drive_end  = (r_state == ST_DRIVE) && (r_cnt == CNT_W'(TICK_LAST));
   assign w_blank_end  = (r_state == ST_BLANK) && (r_cnt == CNT_W'(BLANK_LAST));
   assign w_frame_end  = enable && w_last_idx && ((BLANK_CYCLES == 0) ? w_drive_end : w_blank_end);
   assign w_xfer       = !r_load_ready && ((r_state == ST_IDLE) || w_frame_end);
   assign w_active_nxt = w_xfer ? r_staging : r_active;
   assign w_next_idx   = w_last_idx ? '0 : r_idx + IDX_W'(1);

   // Next slot decode uses the post-transfer value so a new frame shows the new data.
   assign w_next_sel   = f_drive_sel(w_next_idx, w_active_nxt, lz_en);
   assign w_next_nib   = f_nibble(w_next_idx, w_active_nxt);
   assign w_start_sel  = f_drive_sel('0, w_active_nxt, lz_en);
   assign w_start_nib  = f_nibble('0, w_active_nxt);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_idx        <= '0;
         r_cnt        <= '0;
         r_active     <= '0;
         r_staging    <= '0;
         r_load_ready <= 1'b1;
         r_nibble     <= '0;
         r_digit_sel  <= '1;
         r_seg_blank  <= 1'b1;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_frame_end;

         if (w_xfer) begin
            r_active     <= r_staging;
            r_load_ready <= 1'b1;
         end else if (load_valid && r_load_ready) begin
            r_staging    <= load_value;
            r_load_ready <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (enable) begin
                  r_state     <= ST_DRIVE;
                  r_idx       <= '0;
                  r_cnt       <= '0;
                  r_digit_sel <= w_start_sel;
                  r_seg_blank <= &w_start_sel;
                  r_nibble    <= w_start_nib;
               end else begin
                  r_digit_sel <= '1;
                  r_seg_blank <= 1'b1;
               end
            end
            ST_DRIVE: begin
               if (!enable) begin
                  r_state     <= ST_IDLE;
                  r_idx       <= '0;
                  r_cnt       <= '0;
                  r_digit_sel <= '1;
                  r_seg_blank <= 1'b1;
               end else if (w_drive_end) begin
                  r_cnt <= '0;
                  if (BLANK_CYCLES == 0) begin
                     r_idx       <= w_next_idx;
                     r_digit_sel <= w_next_sel;
                     r_seg_blank <= &w_next_sel;
                     r_nibble    <= w_next_nib;
                  end else begin
                     r_state     <= ST_BLANK;
                     r_digit_sel <= '1;
                     r_seg_blank <= 1'b1;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            ST_BLANK: begin
               if (!enable) begin
                  r_state     <= ST_IDLE;
                  r_idx       <= '0;
                  r_cnt       <= '0;
                  r_digit_sel <= '1;
                  r_seg_blank <= 1'b1;
               end else if (w_blank_end) begin
                  r_state     <= ST_DRIVE;
                  r_idx       <= w_next_idx;
                  r_cnt       <= '0;
                  r_digit_sel <= w_next_sel;
                  r_seg_blank <= &w_next_sel;
                  r_nibble    <= w_next_nib;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_idx       <= '0;
               r_cnt       <= '0;
               r_digit_sel <= '1;
               r_seg_blank <= 1'b1;
            end
         endcase
      end
   end

   assign load_ready = r_load_ready;
   assign nibble     = r_nibble;
   assign digit_sel  = r_digit_sel;
   assign seg_blank  = r_seg_blank;
   assign frame_done = r_frame_done;

endmodule
